// File: rtl/rggen_indirect_bank_pkg.sv
// Shared types and register-map constants for the indirect register bank.
package rggen_indirect_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } rggen_indirect_bank_state_e;

  localparam int INDEX_OFFSET  = 0;
  localparam int DATA_OFFSET   = 1;
  localparam int STATUS_OFFSET = 2;

  localparam int STATUS_ERR_BIT      = 0;
  localparam int STATUS_AUTO_INC_BIT = 1;

  function automatic int auto_inc_bit(input int bus_width);
    return bus_width - 1;
  endfunction

  // A single-entry bank still needs a 1-bit index field.
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rggen_indirect_bank_if.sv
// Register-bus request/response bundle between a bus adapter and the bank.
interface rggen_indirect_bank_if #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH-1:0]     write_mask;
  logic                     ready;
  logic [BUS_WIDTH-1:0]     read_data;
  logic                     error;

  modport master (
    output valid, address, write, write_data, write_mask,
    input  ready, read_data, error
  );

  modport slave (
    input  valid, address, write, write_data, write_mask,
    output ready, read_data, error
  );
endinterface

// File: rtl/rggen_indirect_bank_storage.sv
// Entry array with a bit-masked write port, a registered bus read port and a
// registered hardware read port; out-of-range indices read as zero.
module rggen_indirect_bank_storage #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 16,
  parameter int                    IW            = 4,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [IW-1:0]         write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] write_mask,
  input  logic                  read_en,
  input  logic [IW-1:0]         read_index,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic [IW-1:0]         hw_index,
  output logic [DATA_WIDTH-1:0] hw_data
);
  localparam logic [IW:0] DEPTH_LIMIT = (IW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] entries [DEPTH];
  logic                  write_in_range;
  logic                  read_in_range;
  logic                  hw_in_range;

  assign write_in_range = ({1'b0, write_index} < DEPTH_LIMIT);
  assign read_in_range  = ({1'b0, read_index} < DEPTH_LIMIT);
  assign hw_in_range    = ({1'b0, hw_index} < DEPTH_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= INITIAL_VALUE;
      end
    end else if (write_en && write_in_range) begin
      entries[write_index] <= (entries[write_index] & ~write_mask) | (write_data & write_mask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (read_en) begin
      read_data <= read_in_range ? entries[read_index] : '0;
    end
  end

  // Sees the pre-write contents when a bus write commits on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_data <= INITIAL_VALUE;
    end else begin
      hw_data <= hw_in_range ? entries[hw_index] : '0;
    end
  end

endmodule

// File: rtl/rggen_indirect_bank.sv
// Indirect register bank: INDEX/DATA/STATUS window onto a DEPTH-entry array,
// with optional index auto-increment and a sticky range-error flag.
module rggen_indirect_bank
  import rggen_indirect_bank_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH     = 7,
  parameter int                       BUS_WIDTH         = 32,
  parameter int                       DATA_WIDTH        = 32,
  parameter int                       DEPTH             = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS      = '0,
  parameter logic [DATA_WIDTH-1:0]    INITIAL_VALUE     = '0,
  parameter bit                       ERROR_STATUS      = 1'b0,
  parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA = '0,
  localparam int                      IW                = index_width(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rggen_indirect_bank_if.slave   bus,
  input  logic [IW-1:0]          i_hw_index,
  output logic [DATA_WIDTH-1:0]  o_hw_data
);
  localparam int              BYTES        = BUS_WIDTH / 8;
  localparam int              AUTO_INC_BIT = auto_inc_bit(BUS_WIDTH);
  localparam logic [IW:0]     DEPTH_LIMIT  = (IW + 1)'(DEPTH);
  localparam logic [IW-1:0]   LAST_INDEX   = IW'(DEPTH - 1);

  rggen_indirect_bank_state_e state, next_state;

  logic [IW-1:0]            index_r, index_next;
  logic                     auto_inc_r, auto_inc_next;
  logic                     err_r, err_next;
  logic                     oor_r;
  logic                     ready_r;
  logic                     error_r;
  logic [BUS_WIDTH-1:0]     read_data_r;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     hit_index, hit_data, hit_status;
  logic                     accept;
  logic                     index_oor;
  logic                     data_access, data_write, index_write, status_clear;
  logic [BUS_WIDTH-1:0]     resp_data;
  logic                     resp_error;
  logic [DATA_WIDTH-1:0]    storage_read_data;

  assign offset     = bus.address - BASE_ADDRESS;
  assign hit_index  = (offset == ADDRESS_WIDTH'(INDEX_OFFSET * BYTES));
  assign hit_data   = (offset == ADDRESS_WIDTH'(DATA_OFFSET * BYTES));
  assign hit_status = (offset == ADDRESS_WIDTH'(STATUS_OFFSET * BYTES));
  assign index_oor  = ({1'b0, index_r} >= DEPTH_LIMIT);

  assign data_access  = accept && hit_data;
  assign data_write   = data_access && bus.write && !index_oor;
  assign index_write  = accept && hit_index && bus.write;
  assign status_clear = accept && hit_status && bus.write
                        && bus.write_mask[STATUS_ERR_BIT] && bus.write_data[STATUS_ERR_BIT];

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid) begin
          accept     = 1'b1;
          next_state = (hit_data && !bus.write) ? FETCH : RESP;
        end else begin
          next_state = IDLE;
        end
      end
      FETCH:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // INDEX write wins over auto-increment; a bad index always restarts at 0.
  always_comb begin
    index_next    = index_r;
    auto_inc_next = auto_inc_r;
    if (index_write) begin
      index_next    = (index_r & ~bus.write_mask[IW-1:0])
                    | (bus.write_data[IW-1:0] & bus.write_mask[IW-1:0]);
      auto_inc_next = bus.write_mask[AUTO_INC_BIT] ? bus.write_data[AUTO_INC_BIT] : auto_inc_r;
    end else if (data_access && auto_inc_r) begin
      index_next = (index_oor || (index_r == LAST_INDEX)) ? '0 : index_r + IW'(1);
    end else begin
      index_next = index_r;
    end
  end

  always_comb begin
    err_next = err_r;
    if (data_access && index_oor) begin
      err_next = 1'b1;
    end else if (status_clear) begin
      err_next = 1'b0;
    end else begin
      err_next = err_r;
    end
  end

  always_comb begin
    resp_data  = '0;
    resp_error = 1'b0;
    if (hit_index) begin
      if (!bus.write) begin
        resp_data[IW-1:0]         = index_r;
        resp_data[AUTO_INC_BIT]   = auto_inc_r;
      end else begin
        resp_data = '0;
      end
    end else if (hit_status) begin
      if (!bus.write) begin
        resp_data[STATUS_ERR_BIT]      = err_r;
        resp_data[STATUS_AUTO_INC_BIT] = auto_inc_r;
      end else begin
        resp_data = '0;
      end
    end else if (hit_data) begin
      resp_error = index_oor & ERROR_STATUS;
    end else begin
      resp_data  = bus.write ? '0 : DEFAULT_READ_DATA;
      resp_error = ERROR_STATUS;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      index_r     <= '0;
      auto_inc_r  <= 1'b0;
      err_r       <= 1'b0;
      oor_r       <= 1'b0;
      ready_r     <= 1'b0;
      read_data_r <= '0;
      error_r     <= 1'b0;
    end else begin
      state      <= next_state;
      index_r    <= index_next;
      auto_inc_r <= auto_inc_next;
      err_r      <= err_next;
      ready_r    <= (next_state == RESP);
      if (accept) begin
        oor_r <= index_oor;
      end
      case (state)
        IDLE: begin
          if (accept && (next_state == RESP)) begin
            read_data_r <= resp_data;
            error_r     <= resp_error;
          end else begin
            read_data_r <= '0;
            error_r     <= 1'b0;
          end
        end
        FETCH: begin
          read_data_r <= oor_r ? DEFAULT_READ_DATA : BUS_WIDTH'(storage_read_data);
          error_r     <= oor_r & ERROR_STATUS;
        end
        default: begin
          read_data_r <= '0;
          error_r     <= 1'b0;
        end
      endcase
    end
  end

  rggen_indirect_bank_storage #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH),
    .IW            (IW),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_storage (
    .clk         (i_clk),
    .rst         (i_rst),
    .write_en    (data_write),
    .write_index (index_r),
    .write_data  (bus.write_data[DATA_WIDTH-1:0]),
    .write_mask  (bus.write_mask[DATA_WIDTH-1:0]),
    .read_en     (data_access && !bus.write),
    .read_index  (index_r),
    .read_data   (storage_read_data),
    .hw_index    (i_hw_index),
    .hw_data     (o_hw_data)
  );

  assign bus.ready     = ready_r;
  assign bus.read_data = read_data_r;
  assign bus.error     = error_r;

endmodule

// File: tb/tb_rggen_indirect_bank.sv
// Scoreboard bench: bank A (DEPTH 16, INITIAL 5A) and bank B (DEPTH 10, error responses on).
module tb_rggen_indirect_bank;

  localparam logic [6:0] A_INDEX    = 7'h00;
  localparam logic [6:0] A_DATA     = 7'h04;
  localparam logic [6:0] A_STATUS   = 7'h08;
  localparam logic [6:0] A_UNMAPPED = 7'h0C;
  localparam logic [31:0] FULL      = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hw_index_a, hw_index_b;
  logic [31:0] hw_data_a, hw_data_b;
  logic [31:0] hw_first;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  rggen_indirect_bank_if #(.ADDRESS_WIDTH(7), .BUS_WIDTH(32)) bus_a ();
  rggen_indirect_bank_if #(.ADDRESS_WIDTH(7), .BUS_WIDTH(32)) bus_b ();

  rggen_indirect_bank #(
    .ADDRESS_WIDTH(7), .BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
    .BASE_ADDRESS(7'h00), .INITIAL_VALUE(32'h0000_005A), .ERROR_STATUS(1'b0),
    .DEFAULT_READ_DATA(32'hDEAD_BEEF)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a.slave),
    .i_hw_index(hw_index_a), .o_hw_data(hw_data_a)
  );

  rggen_indirect_bank #(
    .ADDRESS_WIDTH(7), .BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(10),
    .BASE_ADDRESS(7'h00), .INITIAL_VALUE(32'h0000_0000), .ERROR_STATUS(1'b1),
    .DEFAULT_READ_DATA(32'h0BAD_0BAD)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b.slave),
    .i_hw_index(hw_index_b), .o_hw_data(hw_data_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [6:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [31:0] wm);
    if (sel) begin
      bus_b.valid = v; bus_b.address = addr; bus_b.write = wr;
      bus_b.write_data = wd; bus_b.write_mask = wm;
    end else begin
      bus_a.valid = v; bus_a.address = addr; bus_a.write = wr;
      bus_a.write_data = wd; bus_a.write_mask = wm;
    end
  endtask

  task automatic access(input string tag, input bit sel, input logic [6:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [31:0] wm,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    exp_t        e;
    int          cycles;
    logic        rdy;
    logic [31:0] got_rd;
    logic        got_err;
    e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    drive(sel, 1'b1, addr, wr, wd, wm);
    cycles = 0;
    rdy    = 1'b0;
    while (!rdy && cycles < 8) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) hw_first = sel ? hw_data_b : hw_data_a;
      rdy = sel ? bus_b.ready : bus_a.ready;
    end
    got_rd  = sel ? bus_b.read_data : bus_a.read_data;
    got_err = sel ? bus_b.error : bus_a.error;
    drive(sel, 1'b0, 7'h00, 1'b0, 32'h0, 32'h0);
    e = sb_q.pop_front();
    check({tag, ".ready"}, {31'h0, rdy}, 32'h1);
    check({tag, ".latency"}, 32'(cycles), 32'(e.lat));
    check({tag, ".rdata"}, got_rd, e.rd);
    check({tag, ".error"}, {31'h0, got_err}, {31'h0, e.err});
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'h0, (sel ? bus_b.ready : bus_a.ready)}, 32'h0);
    check({tag, ".rdata_idle"}, (sel ? bus_b.read_data : bus_a.read_data), 32'h0);
  endtask

  task automatic hw_check(input string tag, input bit sel, input logic [3:0] idx, input logic [31:0] exp);
    @(negedge clk);
    if (sel) hw_index_b = idx; else hw_index_a = idx;
    @(posedge clk); #1;
    check(tag, (sel ? hw_data_b : hw_data_a), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    hw_index_a = 4'd0;
    hw_index_b = 4'd0;
    drive(1'b0, 1'b0, 7'h00, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 7'h00, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst.ready_a", {31'h0, bus_a.ready}, 32'h0);
    check("rst.rdata_a", bus_a.read_data, 32'h0);
    check("rst.hw_a", hw_data_a, 32'h0000_005A);
    check("rst.hw_b", hw_data_b, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Bank A: initial read, auto-increment, hw port, masking, unmapped.
    access("a.init_read", 1'b0, A_DATA, 1'b0, 32'h0, 32'h0, 32'h0000_005A, 1'b0, 2);
    access("a.idx_wr", 1'b0, A_INDEX, 1'b1, 32'h8000_0003, FULL, 32'h0, 1'b0, 1);
    access("a.data_wr_a1", 1'b0, A_DATA, 1'b1, 32'h0000_00A1, FULL, 32'h0, 1'b0, 1);
    access("a.data_wr_b2", 1'b0, A_DATA, 1'b1, 32'h0000_00B2, FULL, 32'h0, 1'b0, 1);
    access("a.idx_rd", 1'b0, A_INDEX, 1'b0, 32'h0, 32'h0, 32'h8000_0005, 1'b0, 1);
    access("a.status_rd", 1'b0, A_STATUS, 1'b0, 32'h0, 32'h0, 32'h0000_0002, 1'b0, 1);
    hw_check("a.hw4", 1'b0, 4'd4, 32'h0000_00B2);
    hw_check("a.hw3", 1'b0, 4'd3, 32'h0000_00A1);
    hw_check("a.hw5", 1'b0, 4'd5, 32'h0000_005A);
    access("a.data_wr_77", 1'b0, A_DATA, 1'b1, 32'h0000_0077, FULL, 32'h0, 1'b0, 1);
    check("a.hw_same_edge_old", hw_first, 32'h0000_005A);
    check("a.hw_new", hw_data_a, 32'h0000_0077);
    access("a.idx_wr2", 1'b0, A_INDEX, 1'b1, 32'h0000_0002, FULL, 32'h0, 1'b0, 1);
    access("a.full_wr", 1'b0, A_DATA, 1'b1, 32'hFFFF_0000, FULL, 32'h0, 1'b0, 1);
    access("a.mask_wr", 1'b0, A_DATA, 1'b1, 32'h0000_1234, 32'h0000_FFFF, 32'h0, 1'b0, 1);
    access("a.mask_rd", 1'b0, A_DATA, 1'b0, 32'h0, 32'h0, 32'hFFFF_1234, 1'b0, 2);
    access("a.unmap_rd", 1'b0, A_UNMAPPED, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
    access("a.unmap_wr", 1'b0, A_UNMAPPED, 1'b1, FULL, FULL, 32'h0, 1'b0, 1);
    access("a.after_unmap_rd", 1'b0, A_DATA, 1'b0, 32'h0, 32'h0, 32'hFFFF_1234, 1'b0, 2);
    access("a.after_unmap_idx", 1'b0, A_INDEX, 1'b0, 32'h0, 32'h0, 32'h0000_0002, 1'b0, 1);
    access("a.status_clean", 1'b0, A_STATUS, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1);

    // Bank B: wrap at DEPTH-1, out-of-range handling, sticky ERR and W1C.
    access("b.idx_wr9", 1'b1, A_INDEX, 1'b1, 32'h8000_0009, FULL, 32'h0, 1'b0, 1);
    access("b.data_wr9", 1'b1, A_DATA, 1'b1, 32'h0000_0011, FULL, 32'h0, 1'b0, 1);
    access("b.idx_wrap", 1'b1, A_INDEX, 1'b0, 32'h0, 32'h0, 32'h8000_0000, 1'b0, 1);
    access("b.idx_wr12", 1'b1, A_INDEX, 1'b1, 32'h0000_000C, FULL, 32'h0, 1'b0, 1);
    access("b.oor_wr", 1'b1, A_DATA, 1'b1, 32'h0000_0022, FULL, 32'h0, 1'b1, 1);
    access("b.oor_rd", 1'b1, A_DATA, 1'b0, 32'h0, 32'h0, 32'h0BAD_0BAD, 1'b1, 2);
    access("b.status_err", 1'b1, A_STATUS, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 1);
    access("b.w1c_masked", 1'b1, A_STATUS, 1'b1, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 1);
    access("b.status_kept", 1'b1, A_STATUS, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 1);
    access("b.w1c", 1'b1, A_STATUS, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1);
    access("b.status_clr", 1'b1, A_STATUS, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      hw_check($sformatf("b.hw%0d", i), 1'b1, 4'(i), (i == 9) ? 32'h0000_0011 : 32'h0);
    end
    hw_check("b.hw_oor", 1'b1, 4'd12, 32'h0);
    access("b.idx_wr12_ai", 1'b1, A_INDEX, 1'b1, 32'h8000_000C, FULL, 32'h0, 1'b0, 1);
    access("b.oor_rd_ai", 1'b1, A_DATA, 1'b0, 32'h0, 32'h0, 32'h0BAD_0BAD, 1'b1, 2);
    access("b.oor_wrap", 1'b1, A_INDEX, 1'b0, 32'h0, 32'h0, 32'h8000_0000, 1'b0, 1);
    access("b.status_both", 1'b1, A_STATUS, 1'b0, 32'h0, 32'h0, 32'h0000_0003, 1'b0, 1);

    // Reset during FETCH aborts the read and clears everything at once.
    @(negedge clk);
    drive(1'b0, 1'b1, A_DATA, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_fetch.ready", {31'h0, bus_a.ready}, 32'h0);
    check("rst_fetch.rdata", bus_a.read_data, 32'h0);
    check("rst_fetch.error", {31'h0, bus_a.error}, 32'h0);
    check("rst_fetch.hw", hw_data_a, 32'h0000_005A);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_fetch.no_ready", {31'h0, bus_a.ready}, 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h00, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    access("a.post_rst_idx", 1'b0, A_INDEX, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    access("a.post_rst_data", 1'b0, A_DATA, 1'b0, 32'h0, 32'h0, 32'h0000_005A, 1'b0, 2);
    hw_check("a.post_rst_hw5", 1'b0, 4'd5, 32'h0000_005A);
    hw_check("a.post_rst_hw3", 1'b0, 4'd3, 32'h0000_005A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
